// File: rtl/note_pkg.sv
// Shared definitions for the note scan scheduler.
//   - PS/2 set-2 scan codes for the seven natural notes, plus the Esc,
//     break-prefix, extended-prefix and blank codes.
//   - Mode encodings presented on the scheduler's mode output.
//   - is_note(): true when a byte is one of the seven note codes.
package note_pkg;

   localparam logic [7:0] NOTE_C     = 8'h23;
   localparam logic [7:0] NOTE_D     = 8'h2D;
   localparam logic [7:0] NOTE_E     = 8'h3A;
   localparam logic [7:0] NOTE_F     = 8'h2B;
   localparam logic [7:0] NOTE_G     = 8'h1B;
   localparam logic [7:0] NOTE_A     = 8'h4B;
   localparam logic [7:0] NOTE_B     = 8'h21;
   localparam logic [7:0] KEY_ESC    = 8'h76;
   localparam logic [7:0] KEY_BRK    = 8'hF0;
   localparam logic [7:0] KEY_EXT    = 8'hE0;
   localparam logic [7:0] CODE_BLANK = 8'h00;

   localparam logic [1:0] MODE_IDLE      = 2'd0;
   localparam logic [1:0] MODE_LIVE      = 2'd1;
   localparam logic [1:0] MODE_PLAY_NOTE = 2'd2;
   localparam logic [1:0] MODE_PLAY_GAP  = 2'd3;

   function automatic logic is_note(input logic [7:0] code);
      case (code)
         NOTE_C, NOTE_D, NOTE_E, NOTE_F,
         NOTE_G, NOTE_A, NOTE_B: is_note = 1'b1;
         default:                is_note = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/note_song_rom.sv
// Demo melody ROM for the note scan scheduler.
//   idx  in  4  melody index
//   code out 8  note scan code at idx; BLANK for idx >= SONG_LEN
// Purely combinational so the scheduler's pending code follows idx directly.
module note_song_rom
   import note_pkg::*;
#(
   parameter int SONG_LEN = 16
) (
   input  logic [3:0] idx,
   output logic [7:0] code
);

   logic [7:0] rom_code;

   always_comb begin
      rom_code = CODE_BLANK;
      case (idx)
         4'd0:  rom_code = NOTE_C;
         4'd1:  rom_code = NOTE_D;
         4'd2:  rom_code = NOTE_E;
         4'd3:  rom_code = NOTE_F;
         4'd4:  rom_code = NOTE_G;
         4'd5:  rom_code = NOTE_A;
         4'd6:  rom_code = NOTE_B;
         4'd7:  rom_code = NOTE_C;   // C on the ledger line
         4'd8:  rom_code = NOTE_C;
         4'd9:  rom_code = NOTE_B;
         4'd10: rom_code = NOTE_A;
         4'd11: rom_code = NOTE_G;
         4'd12: rom_code = NOTE_F;
         4'd13: rom_code = NOTE_E;
         4'd14: rom_code = NOTE_D;
         4'd15: rom_code = NOTE_C;
         default: rom_code = CODE_BLANK;
      endcase
   end

   // A shorter song reads blank past its end.
   assign code = (int'(idx) < SONG_LEN) ? rom_code : CODE_BLANK;

endmodule

// File: rtl/note_scan_scheduler.sv
// Chooses the note code that drives the note/staff display scan input,
// from live PS/2 key bytes or a looping demo melody, and commits changes
// only on the frame tick so a note never changes mid-frame.
//   clk_100MHz   in   1  system clock
//   reset        in   1  asynchronous active-high reset
//   vsync        in   1  display vsync, active-high, clk_100MHz domain
//   kbd_code     in   8  PS/2 byte from the receiver
//   kbd_valid    in   1  one-cycle strobe qualifying kbd_code
//   play_toggle  in   1  one-cycle strobe: start/stop demo playback
//   scan         out  8  committed code for the display
//   mode         out  2  0 IDLE, 1 LIVE, 2 PLAY_NOTE, 3 PLAY_GAP
//   note_idx     out  4  current melody index
//   busy         out  1  high while playing (PLAY_NOTE or PLAY_GAP)
module note_scan_scheduler
   import note_pkg::*;
#(
   parameter int SONG_LEN     = 16,
   parameter int HOLD_FRAMES  = 30,
   parameter int GAP_FRAMES   = 4,
   parameter int IDLE_TIMEOUT = 600
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       vsync,
   input  logic [7:0] kbd_code,
   input  logic       kbd_valid,
   input  logic       play_toggle,
   output logic [7:0] scan,
   output logic [1:0] mode,
   output logic [3:0] note_idx,
   output logic       busy
);

   localparam int FMAX   = (HOLD_FRAMES > GAP_FRAMES) ? HOLD_FRAMES : GAP_FRAMES;
   localparam int FCNT_W = (FMAX > 1) ? $clog2(FMAX) : 1;
   localparam int ICNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

   localparam logic [FCNT_W-1:0] HOLD_LAST = FCNT_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
   localparam logic [FCNT_W-1:0] GAP_LAST  = FCNT_W'((GAP_FRAMES  > 0) ? GAP_FRAMES  - 1 : 0);
   localparam logic [ICNT_W-1:0] IDLE_LAST = ICNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
   localparam logic [ICNT_W-1:0] IDLE_MAX  = '1;
   localparam logic [3:0]        SONG_LAST = 4'((SONG_LEN > 0) ? SONG_LEN - 1 : 0);

   logic              vsync_p1;
   logic              ftick;
   logic              brk;
   logic [7:0]        key_code;      // code shown when not playing
   logic [FCNT_W-1:0] fcnt;
   logic [ICNT_W-1:0] idle_cnt;

   logic [1:0]        mode_n;
   logic [3:0]        idx_n;
   logic [FCNT_W-1:0] fcnt_n;
   logic [ICNT_W-1:0] idle_n;
   logic [7:0]        key_code_n;
   logic [7:0]        rom_code;
   logic [7:0]        pend;
   logic [3:0]        idx_adv;

   logic is_brk, is_ext, data_byte;
   logic press_note, press_esc, release_held;
   logic toggle, no_input;

   note_song_rom #(
      .SONG_LEN (SONG_LEN)
   ) u_rom (
      .idx  (note_idx),
      .code (rom_code)
   );

   // ---- frame tick: rising edge of vsync ----
   assign ftick = vsync & ~vsync_p1;

   // ---- key decode ----
   // E0 is simply dropped so the byte after it decodes as a normal key.
   assign is_brk       = kbd_valid && (kbd_code == KEY_BRK);
   assign is_ext       = kbd_valid && (kbd_code == KEY_EXT);
   assign data_byte    = kbd_valid && !is_brk && !is_ext;
   assign press_note   = data_byte && !brk && is_note(kbd_code);
   assign press_esc    = data_byte && !brk && (kbd_code == KEY_ESC);
   assign release_held = data_byte && brk && (mode == MODE_LIVE) && (kbd_code == key_code);

   // Keyboard activity in the same cycle swallows the toggle.
   assign toggle   = play_toggle && !kbd_valid;
   assign no_input = !kbd_valid && !play_toggle;

   assign idx_adv = (note_idx == SONG_LAST) ? 4'd0 : note_idx + 4'd1;

   // Code that the next frame tick will commit.
   always_comb begin
      case (mode)
         MODE_PLAY_NOTE: pend = rom_code;
         MODE_PLAY_GAP:  pend = CODE_BLANK;
         default:        pend = key_code;
      endcase
   end

   // ---- mode FSM and frame counter ----
   always_comb begin
      mode_n     = mode;
      idx_n      = note_idx;
      fcnt_n     = fcnt;
      key_code_n = key_code;

      if (press_note) begin
         // A note press preempts anything, including playback.
         mode_n     = MODE_LIVE;
         key_code_n = kbd_code;
         idx_n      = 4'd0;
         fcnt_n     = '0;
      end else if (press_esc) begin
         mode_n     = MODE_IDLE;
         key_code_n = KEY_ESC;
         idx_n      = 4'd0;
         fcnt_n     = '0;
      end else if (release_held) begin
         mode_n     = MODE_IDLE;
         key_code_n = CODE_BLANK;
      end else if (toggle) begin
         case (mode)
            MODE_IDLE: begin
               mode_n = MODE_PLAY_NOTE;
               idx_n  = 4'd0;
               fcnt_n = '0;
            end
            MODE_PLAY_NOTE, MODE_PLAY_GAP: begin
               mode_n     = MODE_IDLE;
               key_code_n = CODE_BLANK;
               idx_n      = 4'd0;
               fcnt_n     = '0;
            end
            default: ;   // LIVE ignores the toggle
         endcase
      end else if (ftick) begin
         case (mode)
            MODE_IDLE: begin
               if ((IDLE_TIMEOUT != 0) && no_input && (idle_cnt == IDLE_LAST)) begin
                  mode_n = MODE_PLAY_NOTE;
                  idx_n  = 4'd0;
                  fcnt_n = '0;
               end
            end
            MODE_PLAY_NOTE: begin
               if (fcnt == HOLD_LAST) begin
                  fcnt_n = '0;
                  if (GAP_FRAMES == 0) begin
                     idx_n = idx_adv;
                  end else begin
                     mode_n = MODE_PLAY_GAP;
                  end
               end else begin
                  fcnt_n = fcnt + 1'b1;
               end
            end
            MODE_PLAY_GAP: begin
               if (fcnt == GAP_LAST) begin
                  mode_n = MODE_PLAY_NOTE;
                  idx_n  = idx_adv;
                  fcnt_n = '0;
               end else begin
                  fcnt_n = fcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- idle counter: any input or leaving IDLE clears it; saturates ----
   always_comb begin
      idle_n = idle_cnt;
      if (!no_input || (mode_n != MODE_IDLE)) begin
         idle_n = '0;
      end else if (ftick && (idle_cnt != IDLE_MAX)) begin
         idle_n = idle_cnt + 1'b1;
      end
   end

   // ---- state and output registers ----
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         vsync_p1 <= 1'b0;
         brk      <= 1'b0;
         key_code <= CODE_BLANK;
         fcnt     <= '0;
         idle_cnt <= '0;
         mode     <= MODE_IDLE;
         note_idx <= 4'd0;
         busy     <= 1'b0;
         scan     <= CODE_BLANK;
      end else begin
         vsync_p1 <= vsync;
         if (is_brk) begin
            brk <= 1'b1;
         end else if (data_byte) begin
            brk <= 1'b0;
         end
         key_code <= key_code_n;
         fcnt     <= fcnt_n;
         idle_cnt <= idle_n;
         mode     <= mode_n;
         note_idx <= idx_n;
         busy     <= mode_n[1];
         // Commit uses pend from before this cycle's FSM update.
         if (ftick) begin
            scan <= pend;
         end
      end
   end

endmodule
